r5p_htif: RTL and testbench

HTIF host-side responder for R5P simulation and FPGA benches. Sits on the load/store TCB bus as a subordinate and owns the `tohost`/`fromhost` mailbox. Decodes committed `tohost` commands into a halt with exit code, or a console character on a valid/ready byte stream, then acknowledges through `fromhost`. It is the responder for the HTIF requests the core issues, and replaces ad-hoc snooping of `tohost` stores in testbenches.

---
 rtl/htif_pkg.sv | 46 ++++
 rtl/r5p_htif_if.sv | 32 +++
 rtl/r5p_htif.sv | 143 ++++++++++++++
 tb/tb_r5p_htif.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/htif_pkg.sv
// rtl/htif_pkg.sv - shared HTIF types, register offsets and TCB physical parameters
package htif_pkg;

    typedef enum logic {
        TCB_REFERENCE = 1'b0,
        TCB_MEMORY    = 1'b1
    } tcb_mod_t;

    typedef struct packed {
        int unsigned dly;
        int unsigned dbw;
        int unsigned slw;
        tcb_mod_t    mod;
    } tcb_phy_t;

    localparam tcb_phy_t TCB_PHY_LSU = '{dly: 1, dbw: 32, slw: 8, mod: TCB_MEMORY};

    typedef enum logic [7:0] {
        HTIF_DEV_SYSCALL = 8'd0,
        HTIF_DEV_CONSOLE = 8'd1
    } htif_dev_t;

    typedef enum logic [7:0] {
        HTIF_CMD_GETC = 8'd0,
        HTIF_CMD_PUTC = 8'd1
    } htif_cmd_t;

    // byte offsets within the mailbox window
    localparam logic [3:0] HTIF_TOHOST_LO   = 4'h0;
    localparam logic [3:0] HTIF_TOHOST_HI   = 4'h4;
    localparam logic [3:0] HTIF_FROMHOST_LO = 4'h8;
    localparam logic [3:0] HTIF_FROMHOST_HI = 4'hC;

    typedef enum logic [2:0] {
        HTIF_IDLE,
        HTIF_DECODE,
        HTIF_PUTC,
        HTIF_ACK,
        HTIF_HALT
    } htif_state_t;

    function automatic logic [63:0] htif_ack_value(input logic [63:0] cmd_word);
        return {cmd_word[63:48], 48'h0};
    endfunction

endpackage

// File: rtl/r5p_htif_if.sv
// rtl/r5p_htif_if.sv - TCB bus interface with manager/subordinate modports
interface tcb_if
    import htif_pkg::*;
#(
    parameter tcb_phy_t PHY = TCB_PHY_LSU
)();

    typedef struct packed {
        logic                         wen;
        logic [31:0]                  adr;
        logic [PHY.dbw/PHY.slw-1:0]   ben;
        logic [PHY.dbw-1:0]           wdt;
    } req_t;

    typedef struct packed {
        logic err;
    } sts_t;

    typedef struct packed {
        logic [PHY.dbw-1:0] rdt;
        sts_t               sts;
    } rsp_t;

    logic vld;
    logic rdy;
    req_t req;
    rsp_t rsp;

    modport man (output vld, req, input  rdy, rsp);
    modport sub (input  vld, req, output rdy, rsp);

endinterface

// File: rtl/r5p_htif.sv
// rtl/r5p_htif.sv - HTIF tohost/fromhost mailbox responder on the TCB bus
module r5p_htif
    import htif_pkg::*;
#(
    parameter tcb_phy_t    PHY    = TCB_PHY_LSU,
    parameter int unsigned EXIT_W = 32
)(
    input  logic              clk,
    input  logic              rst,
    tcb_if.sub                tcb,
    output logic              chr_vld,
    output logic [7:0]        chr_dat,
    input  logic              chr_rdy,
    output logic              halt,
    output logic [EXIT_W-1:0] exit_code,
    output logic              busy
);

    localparam int BEN_W = int'(PHY.dbw / PHY.slw);

    htif_state_t state;
    logic [63:0] tohost;
    logic [63:0] fromhost;
    logic [31:0] rsp_rdt;
    logic        rsp_err;

    logic [3:0]  sel;
    logic        idle;
    logic        wr;
    logic        wr_to;
    logic        commit;
    logic [31:0] cur;
    logic [31:0] merged;
    logic [63:0] to_next;
    logic        unused_adr;

    assign tcb.rdy    = 1'b1;
    assign tcb.rsp    = {rsp_rdt, rsp_err};
    assign unused_adr = ^{tcb.req.adr[31:4], tcb.req.adr[1:0]};

    always_comb begin
        sel   = {tcb.req.adr[3:2], 2'b00};
        idle  = (state == HTIF_IDLE);
        wr    = tcb.vld && tcb.req.wen;
        wr_to = wr && ((sel == HTIF_TOHOST_LO) || (sel == HTIF_TOHOST_HI));
        case (sel)
            HTIF_TOHOST_LO:   cur = tohost[31:0];
            HTIF_TOHOST_HI:   cur = tohost[63:32];
            HTIF_FROMHOST_LO: cur = fromhost[31:0];
            default:          cur = fromhost[63:32];
        endcase
        merged = cur;
        for (int b = 0; b < BEN_W; b++) begin
            if (tcb.req.ben[b]) begin
                merged[8*b +: 8] = tcb.req.wdt[8*b +: 8];
            end
        end
        to_next = tohost;
        if (wr_to && idle) begin
            if (sel == HTIF_TOHOST_HI) begin
                to_next[63:32] = merged;
            end else begin
                to_next[31:0] = merged;
            end
        end
        // the low-word shortcut lets RV32 code halt with a single store
        commit = wr_to && idle && (to_next != 64'd0) &&
                 ((sel == HTIF_TOHOST_HI) ||
                  (tcb.req.wdt[0] && (tohost[63:32] == 32'd0)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HTIF_IDLE;
            tohost    <= 64'd0;
            fromhost  <= 64'd0;
            rsp_rdt   <= 32'd0;
            rsp_err   <= 1'b0;
            chr_vld   <= 1'b0;
            chr_dat   <= 8'd0;
            halt      <= 1'b0;
            exit_code <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_rdt <= tcb.vld ? cur : 32'd0;
            rsp_err <= wr_to && !idle;

            if (idle) begin
                tohost <= to_next;
            end
            if (wr && (sel == HTIF_FROMHOST_LO)) begin
                fromhost[31:0] <= merged;
            end
            if (wr && (sel == HTIF_FROMHOST_HI)) begin
                fromhost[63:32] <= merged;
            end

            case (state)
                HTIF_IDLE: begin
                    if (commit) begin
                        state <= HTIF_DECODE;
                        busy  <= 1'b1;
                    end
                end
                HTIF_DECODE: begin
                    if ((tohost[63:56] == HTIF_DEV_SYSCALL) && tohost[0]) begin
                        halt      <= 1'b1;
                        exit_code <= EXIT_W'(tohost[47:1]);
                        state     <= HTIF_HALT;
                    end else if ((tohost[63:56] == HTIF_DEV_CONSOLE) &&
                                 (tohost[55:48] == HTIF_CMD_PUTC)) begin
                        chr_dat <= tohost[7:0];
                        chr_vld <= 1'b1;
                        state   <= HTIF_PUTC;
                    end else begin
                        state <= HTIF_ACK;
                    end
                end
                HTIF_PUTC: begin
                    if (chr_rdy) begin
                        chr_vld <= 1'b0;
                        state   <= HTIF_ACK;
                    end
                end
                HTIF_ACK: begin
                    // placed after the CPU fromhost write so the acknowledge wins
                    fromhost <= htif_ack_value(tohost);
                    tohost   <= 64'd0;
                    busy     <= 1'b0;
                    state    <= HTIF_IDLE;
                end
                HTIF_HALT: begin
                    state <= HTIF_HALT;
                end
                default: begin
                    state <= HTIF_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r5p_htif.sv
// tb/tb_r5p_htif.sv - self-checking bench for r5p_htif with an event-time reference model
module tb_r5p_htif;
    import htif_pkg::*;

    localparam longint NEVER = 64'h7fff_ffff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        chr_rdy = 1'b0;
    logic        chr_vld;
    logic [7:0]  chr_dat;
    logic        halt;
    logic [31:0] exit_code;
    logic        busy;

    int checks = 0;
    int passed = 0;
    int delivered = 0;

    logic [31:0] last_rdt;
    logic        last_err;

    always #5 clk = ~clk;

    tcb_if #(.PHY(TCB_PHY_LSU)) tcb ();

    r5p_htif #(.PHY(TCB_PHY_LSU), .EXIT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .tcb       (tcb),
        .chr_vld   (chr_vld),
        .chr_dat   (chr_dat),
        .chr_rdy   (chr_rdy),
        .halt      (halt),
        .exit_code (exit_code),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // reference model: register contents plus the cycle at which each effect becomes visible
    longint      cyc = 0;
    bit          live = 0;
    logic [63:0] m_to, m_from;
    logic        e_busy, e_halt, e_vld, e_err;
    logic [7:0]  e_dat;
    logic [31:0] e_exit, e_rdt;
    longint      t_busy_on, t_upd, t_halt, t_vld_on;
    logic [15:0] job_devcmd;
    logic [7:0]  job_byte;
    logic [31:0] job_exit;

    task automatic model_step();
        logic [1:0]  wsel;
        logic [31:0] old, nw;
        logic [63:0] v;
        logic        busy_now;
        bit          hs;
        if (rst) begin
            m_to = 0; m_from = 0;
            e_busy = 0; e_halt = 0; e_vld = 0; e_err = 0;
            e_dat = 0; e_exit = 0; e_rdt = 0;
            t_busy_on = NEVER; t_upd = NEVER; t_halt = NEVER; t_vld_on = NEVER;
            job_devcmd = 0; job_byte = 0; job_exit = 0;
            live = 1;
            cyc++;
            return;
        end
        busy_now = e_busy;
        wsel = tcb.req.adr[3:2];
        case (wsel)
            2'd0: old = m_to[31:0];
            2'd1: old = m_to[63:32];
            2'd2: old = m_from[31:0];
            default: old = m_from[63:32];
        endcase
        e_rdt = tcb.vld ? old : 32'd0;
        e_err = tcb.vld && tcb.req.wen && (wsel < 2) && busy_now;
        nw = old;
        for (int b = 0; b < 4; b++) if (tcb.req.ben[b]) nw[8*b +: 8] = tcb.req.wdt[8*b +: 8];
        if (tcb.vld && tcb.req.wen) begin
            if (wsel == 2) m_from[31:0] = nw;
            else if (wsel == 3) m_from[63:32] = nw;
            else if (!busy_now) begin
                v = m_to;
                if (wsel == 1) v[63:32] = nw; else v[31:0] = nw;
                if (v != 0 && (wsel == 1 || (tcb.req.wdt[0] && m_to[63:32] == 0))) begin
                    t_busy_on = cyc + 1;
                    t_halt = NEVER; t_vld_on = NEVER; t_upd = NEVER;
                    job_devcmd = v[63:48];
                    if (v[63:56] == 8'd0 && v[0]) begin
                        t_halt = cyc + 2;
                        job_exit = v[32:1];
                    end else if (v[63:56] == 8'd1 && v[55:48] == 8'd1) begin
                        t_vld_on = cyc + 2;
                        job_byte = v[7:0];
                    end else begin
                        t_upd = cyc + 3;
                    end
                end
                m_to = v;
            end
        end
        hs = e_vld && chr_rdy;
        if (hs) t_upd = cyc + 2;
        if (cyc + 1 == t_upd) begin
            m_to = 0;
            m_from = {job_devcmd, 48'h0};
        end
        e_busy = (cyc + 1 >= t_busy_on) && (cyc + 1 < t_upd);
        e_halt = (cyc + 1 >= t_halt);
        if (cyc + 1 == t_halt) e_exit = job_exit;
        if (cyc + 1 == t_vld_on) begin e_vld = 1; e_dat = job_byte; end
        if (hs) e_vld = 0;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (live) begin
            check("busy", busy, e_busy);
            check("halt", halt, e_halt);
            check("exit_code", exit_code, e_exit);
            check("chr_vld", chr_vld, e_vld);
            if (e_vld) check("chr_dat", chr_dat, e_dat);
            check("rsp_rdt", tcb.rsp.rdt, e_rdt);
            check("rsp_err", tcb.rsp.sts.err, e_err);
            if (!rst && chr_vld && chr_rdy) delivered++;
        end
        model_step();
    end

    task automatic xfer(input logic [3:0] adr, input logic wen, input logic [31:0] wdt, input logic [3:0] ben);
        @(posedge clk); #1;
        tcb.vld = 1'b1;
        tcb.req.wen = wen;
        tcb.req.adr = {28'd0, adr};
        tcb.req.ben = ben;
        tcb.req.wdt = wdt;
        @(posedge clk); #1;
        tcb.vld = 1'b0;
        tcb.req = '0;
        last_rdt = tcb.rsp.rdt;
        last_err = tcb.rsp.sts.err;
    endtask

    task automatic poll_tohost(input string name);
        for (int i = 0; i < 12; i++) begin
            xfer(HTIF_TOHOST_LO, 1'b0, 32'd0, 4'hF);
            if (last_rdt == 32'd0) break;
        end
        check(name, last_rdt, 32'd0);
    endtask

    task automatic wait_chr_vld(input string name);
        for (int i = 0; i < 10 && chr_vld !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check(name, chr_vld, 1'b1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tcb.vld = 1'b0;
        tcb.req = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_halt", halt, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_chr_vld", chr_vld, 1'b0);
        check("rst_chr_dat", chr_dat, 8'h00);
        check("rst_exit", exit_code, 32'd0);
        xfer(HTIF_FROMHOST_HI, 1'b0, 32'd0, 4'hF);
        check("rst_fromhost_hi", last_rdt, 32'd0);

        // readback latency with partial byte enables
        xfer(HTIF_FROMHOST_LO, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        xfer(HTIF_FROMHOST_LO, 1'b0, 32'd0, 4'hF);
        check("rb_rdt", last_rdt, 32'h0000_BEEF);
        check("rb_err", last_err, 1'b0);

        // odd bytes written to tohost_lo take the halt shortcut, so use an even character
        chr_rdy = 1'b0;
        xfer(HTIF_TOHOST_LO, 1'b1, 32'h0000_0042, 4'hF);
        xfer(HTIF_TOHOST_HI, 1'b1, 32'h0101_0000, 4'hF);
        check("putc_busy", busy, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_chr_vld", chr_vld, 1'b1);
            check("bp_chr_dat", chr_dat, 8'h42);
            @(posedge clk); #1;
        end
        xfer(HTIF_TOHOST_HI, 1'b1, 32'h0101_0000, 4'hF);
        check("drop_err", last_err, 1'b1);
        xfer(HTIF_TOHOST_LO, 1'b0, 32'd0, 4'hF);
        check("drop_lo", last_rdt, 32'h0000_0042);
        check("read_no_err", last_err, 1'b0);
        xfer(HTIF_TOHOST_HI, 1'b0, 32'd0, 4'hF);
        check("drop_hi", last_rdt, 32'h0101_0000);
        check("bp_still_vld", chr_vld, 1'b1);
        check("bp_none_yet", delivered, 0);
        chr_rdy = 1'b1;
        poll_tohost("putc_tohost_clear");
        xfer(HTIF_FROMHOST_HI, 1'b0, 32'd0, 4'hF);
        check("putc_fromhost_hi", last_rdt, 32'h0101_0000);
        xfer(HTIF_FROMHOST_LO, 1'b0, 32'd0, 4'hF);
        check("putc_fromhost_lo", last_rdt, 32'd0);
        check("putc_one_byte", delivered, 1);

        // reset in the middle of a putchar
        chr_rdy = 1'b0;
        xfer(HTIF_TOHOST_LO, 1'b1, 32'h0000_0044, 4'hF);
        xfer(HTIF_TOHOST_HI, 1'b1, 32'h0101_0000, 4'hF);
        wait_chr_vld("mid_vld_up");
        pulse_reset();
        check("mid_chr_vld", chr_vld, 1'b0);
        check("mid_chr_dat", chr_dat, 8'h00);
        check("mid_busy", busy, 1'b0);
        check("mid_halt", halt, 1'b0);
        xfer(HTIF_TOHOST_LO, 1'b0, 32'd0, 4'hF);
        check("mid_tohost", last_rdt, 32'd0);
        check("mid_no_byte", delivered, 1);

        chr_rdy = 1'b1;
        xfer(HTIF_TOHOST_LO, 1'b1, 32'h0000_0048, 4'hF);
        xfer(HTIF_TOHOST_HI, 1'b1, 32'h0101_0000, 4'hF);
        poll_tohost("putc2_tohost_clear");
        check("putc2_bytes", delivered, 2);

        // non-console command and a zero commit
        xfer(HTIF_TOHOST_HI, 1'b1, 32'h0203_0000, 4'hF);
        poll_tohost("other_tohost_clear");
        xfer(HTIF_FROMHOST_HI, 1'b0, 32'd0, 4'hF);
        check("other_fromhost_hi", last_rdt, 32'h0203_0000);
        xfer(HTIF_TOHOST_HI, 1'b1, 32'd0, 4'hF);
        check("zero_commit_idle", busy, 1'b0);

        // halt with exit code 0
        xfer(HTIF_TOHOST_LO, 1'b1, 32'h0000_0001, 4'hF);
        check("halt_not_yet", halt, 1'b0);
        xfer(HTIF_TOHOST_HI, 1'b1, 32'd0, 4'hF);
        check("halt_hi_err", last_err, 1'b1);
        check("halt_set", halt, 1'b1);
        check("halt_exit0", exit_code, 32'd0);
        xfer(HTIF_TOHOST_LO, 1'b1, 32'h0000_0005, 4'hF);
        check("halt_late_err", last_err, 1'b1);
        xfer(HTIF_TOHOST_LO, 1'b0, 32'd0, 4'hF);
        check("halt_keeps_tohost", last_rdt, 32'h0000_0001);

        // failure code through the shortcut
        pulse_reset();
        xfer(HTIF_TOHOST_LO, 1'b1, 32'h0000_0007, 4'hF);
        @(posedge clk); #1;
        check("fail_halt", halt, 1'b1);
        check("fail_exit", exit_code, 32'd3);

        pulse_reset();
        xfer(HTIF_TOHOST_LO, 1'b1, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        check("max_exit", exit_code, 32'h7FFF_FFFF);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
